// File: rtl/design_arb_pkg.sv
// Shared definitions for the two-requester downstream arbiter: controller
// state encoding, default operand width and default downstream wait budget.
package design_arb_pkg;

    localparam int ARB_W_DEF       = 5;
    localparam int ARB_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_RESP  = 3'd4
    } arb_state_e;

    // Requester index (0 or 1) to its one-hot response/ready lane.
    function automatic logic [1:0] idx_to_onehot2(input logic idx);
        logic [1:0] oh_v;
        if (idx == 1'b1) begin
            oh_v = 2'b10;
        end else begin
            oh_v = 2'b01;
        end
        return oh_v;
    endfunction

endpackage

// File: rtl/design_req_arbiter_rr_grant2.sv
// Two-way round-robin grant: the requester that was not served last wins a
// tie; a lone requester always wins. Purely combinational.
module rr_grant2
    import design_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] grant
);

    // Pick the winner, favouring the requester opposite to the last grant.
    always_comb begin
        grant = 2'b00;
        if (last_gnt == 1'b1) begin
            if (req[0]) begin
                grant = 2'b01;
            end else if (req[1]) begin
                grant = 2'b10;
            end else begin
                grant = 2'b00;
            end
        end else begin
            if (req[1]) begin
                grant = 2'b10;
            end else if (req[0]) begin
                grant = 2'b01;
            end else begin
                grant = 2'b00;
            end
        end
    end

endmodule

// File: rtl/design_req_arbiter.sv
// Arbiter that serialises two requesters onto one downstream unit exposing
// start / result / check methods. One transaction is in flight at a time:
// grant, start the unit, wait (bounded) for result and check readiness,
// capture both, then hold the response until the owner consumes it.
module design_req_arbiter
    import design_arb_pkg::*;
#(
    parameter int W       = ARB_W_DEF,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [1:0]     EN_req,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    input  logic [2*W-1:0] req_c,
    input  logic [2*W-1:0] req_d,
    output logic [1:0]     RDY_req,
    output logic [W-1:0]   resp_result,
    output logic [W-1:0]   resp_check,
    output logic           resp_err,
    output logic [1:0]     RDY_resp,
    input  logic [1:0]     EN_resp,
    output logic [W-1:0]   dut_a,
    output logic [W-1:0]   dut_b,
    output logic           EN_dut_start,
    input  logic           RDY_dut_start,
    output logic [W-1:0]   dut_c,
    input  logic [W-1:0]   dut_result,
    input  logic           RDY_dut_result,
    output logic [W-1:0]   dut_d,
    output logic           EN_dut_check,
    input  logic [W-1:0]   dut_check,
    input  logic           RDY_dut_check
);

    localparam int            CW       = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    arb_state_e    st_r;
    logic          armed_r;       // low in reset and the first cycle after it
    logic          last_r;        // index of the requester served most recently
    logic          owner_r;       // index of the requester being served
    logic          start_act_r;   // start method is being offered downstream
    logic          chk_act_r;     // check method strobe
    logic [CW-1:0] cnt_r;         // WAIT cycles spent, saturating
    logic [W-1:0]  lat_c_r;
    logic [W-1:0]  lat_d_r;
    logic [W-1:0]  dut_a_r;
    logic [W-1:0]  dut_b_r;
    logic [W-1:0]  dut_c_r;
    logic [W-1:0]  dut_d_r;
    logic [W-1:0]  resp_result_r;
    logic [W-1:0]  resp_check_r;
    logic          resp_err_r;
    logic [1:0]    rdy_resp_r;

    logic [1:0]    gnt_s;
    logic          gnt_idx_s;
    logic          accept_s;
    logic          resp_take_s;
    logic [CW-1:0] cnt_inc_s;
    logic [W-1:0]  sel_a_s;
    logic [W-1:0]  sel_b_s;
    logic [W-1:0]  sel_c_s;
    logic [W-1:0]  sel_d_s;

    rr_grant2 u_rr_grant2 (
        .req      (EN_req),
        .last_gnt (last_r),
        .grant    (gnt_s)
    );

    // Acceptance qualification, counter increment and response consumption.
    always_comb begin
        gnt_idx_s = gnt_s[1];
        if (armed_r && (st_r == ST_IDLE) && (gnt_s != 2'b00)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if ((EN_resp & rdy_resp_r) != 2'b00) begin
            resp_take_s = 1'b1;
        end else begin
            resp_take_s = 1'b0;
        end
        cnt_inc_s = cnt_r + CW'(1);
    end

    // Operand slices of the winning requester.
    always_comb begin
        if (gnt_idx_s == 1'b1) begin
            sel_a_s = req_a[2*W-1:W];
            sel_b_s = req_b[2*W-1:W];
            sel_c_s = req_c[2*W-1:W];
            sel_d_s = req_d[2*W-1:W];
        end else begin
            sel_a_s = req_a[W-1:0];
            sel_b_s = req_b[W-1:0];
            sel_c_s = req_c[W-1:0];
            sel_d_s = req_d[W-1:0];
        end
    end

    // Handshake strobes that must follow the partner's ready within the cycle.
    always_comb begin
        if (accept_s) begin
            RDY_req = gnt_s;
        end else begin
            RDY_req = 2'b00;
        end
        if (start_act_r) begin
            EN_dut_start = RDY_dut_start;
        end else begin
            EN_dut_start = 1'b0;
        end
    end

    assign dut_a        = dut_a_r;
    assign dut_b        = dut_b_r;
    assign dut_c        = dut_c_r;
    assign dut_d        = dut_d_r;
    assign EN_dut_check = chk_act_r;
    assign resp_result  = resp_result_r;
    assign resp_check   = resp_check_r;
    assign resp_err     = resp_err_r;
    assign RDY_resp     = rdy_resp_r;

    // Transaction controller; reset drops any in-flight transaction and its strobes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_r          <= ST_IDLE;
            armed_r       <= 1'b0;
            last_r        <= 1'b1;
            owner_r       <= 1'b0;
            start_act_r   <= 1'b0;
            chk_act_r     <= 1'b0;
            cnt_r         <= '0;
            lat_c_r       <= '0;
            lat_d_r       <= '0;
            dut_a_r       <= '0;
            dut_b_r       <= '0;
            dut_c_r       <= '0;
            dut_d_r       <= '0;
            resp_result_r <= '0;
            resp_check_r  <= '0;
            resp_err_r    <= 1'b0;
            rdy_resp_r    <= 2'b00;
        end else begin
            armed_r <= 1'b1;
            case (st_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r     <= gnt_idx_s;
                        last_r      <= gnt_idx_s;
                        dut_a_r     <= sel_a_s;
                        dut_b_r     <= sel_b_s;
                        lat_c_r     <= sel_c_s;
                        lat_d_r     <= sel_d_s;
                        start_act_r <= 1'b1;
                        st_r        <= ST_START;
                    end else begin
                        st_r <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (RDY_dut_start) begin
                        start_act_r <= 1'b0;
                        dut_a_r     <= '0;
                        dut_b_r     <= '0;
                        cnt_r       <= '0;
                        st_r        <= ST_WAIT;
                    end else begin
                        st_r <= ST_START;
                    end
                end
                ST_WAIT: begin
                    if (RDY_dut_result && RDY_dut_check) begin
                        dut_c_r   <= lat_c_r;
                        dut_d_r   <= lat_d_r;
                        chk_act_r <= 1'b1;
                        st_r      <= ST_CHECK;
                    end else begin
                        if (cnt_r != TO_LIMIT) begin
                            cnt_r <= cnt_inc_s;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                        if ((cnt_inc_s == TO_LIMIT) || (cnt_r == TO_LIMIT)) begin
                            resp_result_r <= '0;
                            resp_check_r  <= '0;
                            resp_err_r    <= 1'b1;
                            rdy_resp_r    <= idx_to_onehot2(owner_r);
                            st_r          <= ST_RESP;
                        end else begin
                            st_r <= ST_WAIT;
                        end
                    end
                end
                ST_CHECK: begin
                    chk_act_r     <= 1'b0;
                    dut_c_r       <= '0;
                    dut_d_r       <= '0;
                    resp_result_r <= dut_result;
                    resp_check_r  <= dut_check;
                    resp_err_r    <= 1'b0;
                    rdy_resp_r    <= idx_to_onehot2(owner_r);
                    st_r          <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_take_s) begin
                        rdy_resp_r    <= 2'b00;
                        resp_result_r <= '0;
                        resp_check_r  <= '0;
                        resp_err_r    <= 1'b0;
                        st_r          <= ST_IDLE;
                    end else begin
                        st_r <= ST_RESP;
                    end
                end
                default: begin
                    start_act_r   <= 1'b0;
                    chk_act_r     <= 1'b0;
                    dut_a_r       <= '0;
                    dut_b_r       <= '0;
                    dut_c_r       <= '0;
                    dut_d_r       <= '0;
                    rdy_resp_r    <= 2'b00;
                    resp_result_r <= '0;
                    resp_check_r  <= '0;
                    resp_err_r    <= 1'b0;
                    st_r          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_design_req_arbiter.sv
// Bench for design_req_arbiter: the bench plays both requesters and the
// downstream unit; expected responses are queued at grant time and compared
// when the response appears.
module tb_design_req_arbiter;

    localparam int W  = 5;
    localparam int TO = 15;

    typedef struct {
        int           idx;
        logic [W-1:0] res;
        logic [W-1:0] chk;
        logic         err;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic [1:0]     EN_req;
    logic [2*W-1:0] req_a, req_b, req_c, req_d;
    logic [1:0]     RDY_req;
    logic [W-1:0]   resp_result, resp_check;
    logic           resp_err;
    logic [1:0]     RDY_resp;
    logic [1:0]     EN_resp;
    logic [W-1:0]   dut_a, dut_b, dut_c, dut_d;
    logic           EN_dut_start, RDY_dut_start;
    logic [W-1:0]   dut_result, dut_check;
    logic           RDY_dut_result, RDY_dut_check, EN_dut_check;

    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];
    logic [W-1:0] op_c [2];
    logic [W-1:0] op_d [2];
    logic         ds_fixed, ds_res_rdy;
    logic [W-1:0] fix_res, fix_chk, lat_a, lat_b;

    assign req_a = {op_a[1], op_a[0]};
    assign req_b = {op_b[1], op_b[0]};
    assign req_c = {op_c[1], op_c[0]};
    assign req_d = {op_d[1], op_d[0]};
    assign dut_result     = ds_fixed ? fix_res : W'(lat_a + lat_b);
    assign dut_check      = ds_fixed ? fix_chk : (dut_c ^ dut_d);
    assign RDY_dut_result = ds_res_rdy;
    assign RDY_dut_check  = ds_res_rdy;

    design_req_arbiter #(.W(W), .TIMEOUT(TO)) u_dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .EN_req         (EN_req),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_c          (req_c),
        .req_d          (req_d),
        .RDY_req        (RDY_req),
        .resp_result    (resp_result),
        .resp_check     (resp_check),
        .resp_err       (resp_err),
        .RDY_resp       (RDY_resp),
        .EN_resp        (EN_resp),
        .dut_a          (dut_a),
        .dut_b          (dut_b),
        .EN_dut_start   (EN_dut_start),
        .RDY_dut_start  (RDY_dut_start),
        .dut_c          (dut_c),
        .dut_result     (dut_result),
        .RDY_dut_result (RDY_dut_result),
        .dut_d          (dut_d),
        .EN_dut_check   (EN_dut_check),
        .dut_check      (dut_check),
        .RDY_dut_check  (RDY_dut_check)
    );

    always #5 CLK = ~CLK;

    int           n_chk = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           pend [2];
    logic [1:0]   dec;
    int           stall_cfg, stall_left, stall_used, hold_cfg, hold_left;
    bit           in_start, resp_seen, prev_chk_en, exp_to, fired;
    int           acc_cyc, fire_cyc;
    logic [W-1:0] cur_a, cur_b, cur_c, cur_d;
    logic [1:0]   en_resp_nx;
    logic [31:0]  snap;
    exp_t         sb [$];
    int           exp_gnt [$];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic rst_checks();
        chk_val("rst_strobes", 32'({RDY_req, EN_dut_start, EN_dut_check, RDY_resp}), 32'd0);
        chk_val("rst_dut_data", 32'({dut_a, dut_b, dut_c, dut_d}), 32'd0);
        chk_val("rst_resp", 32'({resp_result, resp_check, resp_err}), 32'd0);
    endtask

    // Drive inputs just after the active edge from decisions taken at the last negedge.
    task automatic apply();
        for (int i = 0; i < 2; i++) begin
            if (dec[i] && (pend[i] > 0)) pend[i]--;
        end
        dec = 2'b00;
        EN_req = {(pend[1] > 0), (pend[0] > 0)};
        RDY_dut_start = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        EN_resp = en_resp_nx;
    endtask

    // Sample and check at the negedge; also act as requesters/consumer.
    task automatic observe();
        exp_t e;
        int   gi;
        cyc++;
        // start method
        chk_val("start_en", 32'(EN_dut_start), 32'(in_start && RDY_dut_start));
        if (in_start) begin
            chk_val("start_ab", 32'({dut_a, dut_b}), 32'({cur_a, cur_b}));
        end else begin
            chk_val("ab_idle", 32'({dut_a, dut_b}), 32'd0);
        end
        if (EN_dut_start) begin
            chk_val("start_lat", 32'(cyc - acc_cyc), 32'(1 + stall_used));
            fire_cyc = cyc;
            fired    = 1'b1;
            lat_a    = dut_a;
            lat_b    = dut_b;
            in_start = 1'b0;
        end
        // check method
        if (EN_dut_check) begin
            chk_val("check_pulse", 32'(prev_chk_en), 32'd0);
            chk_val("check_cd", 32'({dut_c, dut_d}), 32'({cur_c, cur_d}));
        end else begin
            chk_val("cd_idle", 32'({dut_c, dut_d}), 32'd0);
        end
        prev_chk_en = EN_dut_check;
        // response side
        if (RDY_resp != 2'b00) begin
            if (!resp_seen) begin
                resp_seen = 1'b1;
                if (sb.size() == 0) begin
                    chk_val("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk_val("resp_rdy", 32'(RDY_resp), (e.idx == 1) ? 32'd2 : 32'd1);
                    chk_val("resp_result", 32'(resp_result), 32'(e.res));
                    chk_val("resp_check", 32'(resp_check), 32'(e.chk));
                    chk_val("resp_err", 32'(resp_err), 32'(e.err));
                    chk_val("resp_lat", 32'(cyc - fire_cyc), e.err ? 32'(TO + 1) : 32'd3);
                end
                snap      = 32'({RDY_resp, resp_result, resp_check, resp_err});
                hold_left = hold_cfg;
            end else begin
                chk_val("resp_hold", 32'({RDY_resp, resp_result, resp_check, resp_err}), snap);
            end
            chk_val("resp_noreq", 32'(RDY_req), 32'd0);
            if (hold_left == 0) begin
                en_resp_nx = RDY_resp;
            end else begin
                hold_left--;
                en_resp_nx = 2'b00;
            end
        end else begin
            resp_seen  = 1'b0;
            en_resp_nx = 2'b00;
        end
        // request side
        if (RDY_req != 2'b00) begin
            chk_val("req_legal", 32'($onehot(RDY_req) && ((RDY_req & ~EN_req) == 2'b00)), 32'd1);
            gi = RDY_req[1] ? 1 : 0;
            if (exp_gnt.size() > 0) chk_val("grant_order", 32'(gi), 32'(exp_gnt.pop_front()));
            e.idx = gi;
            e.err = exp_to;
            if (exp_to) begin
                e.res = '0;
                e.chk = '0;
            end else if (ds_fixed) begin
                e.res = fix_res;
                e.chk = fix_chk;
            end else begin
                e.res = W'(op_a[gi] + op_b[gi]);
                e.chk = op_c[gi] ^ op_d[gi];
            end
            sb.push_back(e);
            cur_a = op_a[gi];
            cur_b = op_b[gi];
            cur_c = op_c[gi];
            cur_d = op_d[gi];
            acc_cyc    = cyc;
            in_start   = 1'b1;
            stall_used = stall_cfg;
            stall_left = stall_cfg;
            dec[gi]    = 1'b1;
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        apply();
        @(negedge CLK);
        observe();
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && (n < max_cyc)) begin
            cycle();
            n++;
            done = (pend[0] == 0) && (pend[1] == 0) && (sb.size() == 0) && !resp_seen && !in_start;
        end
        chk_val(tag, 32'(done), 32'd1);
        chk_val({tag, "_grants"}, 32'(exp_gnt.size()), 32'd0);
    endtask

    task automatic clear_bench();
        sb.delete();
        exp_gnt.delete();
        pend[0] = 0; pend[1] = 0;
        dec = 2'b00;
        in_start = 1'b0; resp_seen = 1'b0; prev_chk_en = 1'b0;
        stall_left = 0; hold_left = 0; en_resp_nx = 2'b00;
    endtask

    initial begin
        RST_N = 1'b0;
        EN_req = 2'b00; EN_resp = 2'b00; RDY_dut_start = 1'b1;
        ds_fixed = 1'b0; ds_res_rdy = 1'b1; fix_res = '0; fix_chk = '0; lat_a = '0; lat_b = '0;
        for (int i = 0; i < 2; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; op_d[i] = '0;
        end
        stall_cfg = 0; hold_cfg = 0; exp_to = 1'b0; fired = 1'b0;
        acc_cyc = 0; fire_cyc = 0; stall_used = 0; snap = '0;
        cur_a = '0; cur_b = '0; cur_c = '0; cur_d = '0;
        clear_bench();

        // reset values
        repeat (3) begin
            cycle();
            rst_checks();
        end
        #2 RST_N = 1'b1;
        cycle();

        // both requesting continuously: 0,1,0,1
        op_a[0] = 5'd3;  op_b[0] = 5'd4;  op_c[0] = 5'd1; op_d[0] = 5'd2;
        op_a[1] = 5'd10; op_b[1] = 5'd25; op_c[1] = 5'd6; op_d[1] = 5'd12;
        pend[0] = 2; pend[1] = 2;
        exp_gnt = '{0, 1, 0, 1};
        wait_done("alternate", 200);

        // single request, fixed downstream result 7 / check 9
        ds_fixed = 1'b1; fix_res = 5'd7; fix_chk = 5'd9;
        pend[0] = 1;
        wait_done("single", 100);
        ds_fixed = 1'b0;

        // start ready withheld for 4 cycles
        op_a[1] = 5'd9; op_b[1] = 5'd20; op_c[1] = 5'd5; op_d[1] = 5'd17;
        stall_cfg = 4;
        pend[1] = 1;
        wait_done("start_stall", 100);
        stall_cfg = 0;

        // result never ready: timeout
        ds_res_rdy = 1'b0; exp_to = 1'b1;
        pend[0] = 1;
        wait_done("timeout", 100);
        ds_res_rdy = 1'b1; exp_to = 1'b0;

        // response withheld while the other requester waits
        hold_cfg = 10;
        pend[0] = 1; pend[1] = 1;
        exp_gnt = '{1, 0};
        wait_done("resp_hold", 200);
        hold_cfg = 0;

        // reset while waiting on the downstream result
        ds_res_rdy = 1'b0;
        fired = 1'b0;
        pend[0] = 1;
        for (int n = 0; (n < 50) && !fired; n++) cycle();
        chk_val("mid_fired", 32'(fired), 32'd1);
        repeat (3) cycle();
        #2 RST_N = 1'b0;
        #1 rst_checks();
        clear_bench();
        repeat (2) begin
            cycle();
            rst_checks();
        end
        ds_res_rdy = 1'b1;
        pend[0] = 1; pend[1] = 1;
        exp_gnt = '{0, 1};
        cycle();
        rst_checks();
        #2 RST_N = 1'b1;
        wait_done("after_reset", 200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
